// File: rtl/pb_press_detect.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce, and a
// short/long press classifier producing single-cycle release/long pulses.
module pb_press_detect #(
    parameter int unsigned DB_CYCLES   = 1000,
    parameter int unsigned LONG_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } state_t;

    logic              sync1;
    logic              pb_s;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_cnt_next;
    logic              pressed_next;
    logic              rise;
    logic              fall;
    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              released_next;
    logic              long_next;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            pb_s  <= 1'b0;
        end else begin
            sync1 <= PB;
            pb_s  <= sync1;
        end
    end

    // Debounce: count consecutive disagreeing cycles, toggle on the last one
    always_comb begin
        db_cnt_next  = '0;
        pressed_next = pressed;
        if (pb_s != pressed) begin
            if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                pressed_next = ~pressed;
            end else begin
                db_cnt_next = db_cnt + DB_W'(1);
            end
        end
        rise = pressed_next & ~pressed;
        fall = ~pressed_next & pressed;
    end

    // Press classifier; a release on the threshold edge wins over long press
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        released_next = 1'b0;
        long_next     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next    = SHORT;
                    hold_cnt_next = '0;
                end
            end
            SHORT: begin
                if (fall) begin
                    state_next    = IDLE;
                    released_next = 1'b1;
                end else if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            pressed    <= 1'b0;
            state      <= IDLE;
            hold_cnt   <= '0;
            released   <= 1'b0;
            long_press <= 1'b0;
        end else begin
            db_cnt     <= db_cnt_next;
            pressed    <= pressed_next;
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            released   <= released_next;
            long_press <= long_next;
        end
    end

endmodule

// File: doc/pb_press_detect.md
PB_PRESS_DETECT -- requirements
Module: pb_press_detect

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000, meaning consecutive synchronized cycles required to accept a PB level change; legal range >= 2.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 25_000_000, meaning debounced-pressed cycles before a long press is declared; legal range >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all flops are on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port PB, input, 1 bit: raw push-button level, asynchronous to clk, 1 = pressed.
REQ-006 The block SHALL have port pressed, output, 1 bit: debounced button level, registered.
REQ-007 The block SHALL have port released, output, 1 bit: one-cycle pulse on debounced release of a short press, registered.
REQ-008 The block SHALL have port long_press, output, 1 bit: one-cycle pulse when a hold reaches LONG_CYCLES, registered.

Function
REQ-009 PB SHALL pass through a 2-flop synchronizer; pb_s is the second-flop output, with no combinational path from PB to any output.
REQ-010 The debounce counter SHALL be $clog2(DB_CYCLES)+1 bits wide, SHALL increment each cycle pb_s != pressed, and SHALL clear on any cycle pb_s == pressed.
REQ-011 When the debounce counter equals DB_CYCLES-1 and pb_s != pressed, pressed SHALL toggle on the next edge and the counter SHALL clear.
REQ-012 If PB changes and is first sampled at edge n, then stays stable, pressed SHALL change at edge n+DB_CYCLES+1.
REQ-013 A glitch on pb_s lasting fewer than DB_CYCLES cycles SHALL NOT change pressed.
REQ-014 The FSM SHALL have three states: IDLE (pressed=0), SHORT (pressed, long not yet declared) and LONG (long already declared).
REQ-015 The FSM SHALL move from IDLE to SHORT on the edge where pressed rises, and the hold counter SHALL clear at that edge.
REQ-016 In SHORT, the hold counter ($clog2(LONG_CYCLES)+1 bits) SHALL increment each cycle.
REQ-017 When the hold counter equals LONG_CYCLES-1, the FSM SHALL move from SHORT to LONG and long_press SHALL be 1 for exactly the following cycle, i.e. pressed rising at edge m gives long_press high from edge m+LONG_CYCLES.
REQ-018 When pressed falls while in SHORT, the FSM SHALL move to IDLE and released SHALL be 1 for exactly the following cycle.
REQ-019 When pressed falls while in LONG, the FSM SHALL move to IDLE and released SHALL stay 0.
REQ-020 If the long threshold and the debounced release fall on the same edge, the release SHALL take priority: released pulses, long_press stays 0, and the next state is IDLE.
REQ-021 The hold counter SHALL NOT wrap: it SHALL hold its value in LONG.
REQ-022 released and long_press SHALL never both be 1 in the same cycle, and neither SHALL be 1 for two consecutive cycles.
REQ-023 At most one released or long_press pulse SHALL occur per debounced press.

Reset
REQ-024 While rst_n is 0 at a clk edge, the synchronizer flops, both counters, pressed, released and long_press SHALL all be 0, and the state SHALL be IDLE.
REQ-025 Reset asserted mid-press SHALL abort the press with no pulse; if PB is still 1 after reset deasserts, a new press SHALL be detected per REQ-012.
REQ-026 No output SHALL pulse in the first cycle after reset deassertion.

Verification (benches override DB_CYCLES=4, LONG_CYCLES=20)
REQ-027 Short press: PB=1 sampled at edge 10, held 12 cycles, then 0 -> pressed 1 at edge 15; released pulses one cycle after pressed falls; long_press stays 0.
REQ-028 Bounce: PB toggles 1/0 every 2 cycles for 20 cycles, then settles at 1 -> pressed stays 0 during the bounce and rises 5 edges after the settling sample; PB then settles at 0 -> exactly one released pulse.
REQ-029 Long press: pressed rises at edge m, PB held 40 cycles -> long_press high for one cycle at edge m+20; release -> no released pulse.
REQ-030 Tie: the debounced release lands on edge m+20 -> released pulses once and long_press stays 0.
REQ-031 Reset mid-hold: rst_n=0 for 2 cycles at hold count 10, PB kept 1 -> all outputs 0 during reset; pressed re-rises 5 edges after the first post-reset sample; long_press fires 20 cycles after that.
REQ-032 Back-to-back: two short presses separated by 6 idle cycles -> exactly two released pulses, each one cycle wide.
